// File: rtl/risc_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_ctl_pkg
// Description : Shared definitions for the RISC control sequencer: opcode
//               codes, the 4-bit state encoding that is exported on the
//               phase port, and the strobe bundle driven every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_ctl_pkg;

  // Opcode codes (low three bits of the IR opcode field)
  localparam logic [2:0] HLT  = 3'd0;
  localparam logic [2:0] SKZ  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4;
  localparam logic [2:0] LDA  = 3'd5;
  localparam logic [2:0] STO  = 3'd6;
  localparam logic [2:0] JMP  = 3'd7;

  // Fetch phases occupy codes 0..3 so the low two bits are the fetch index.
  typedef enum logic [3:0] {
    ST_FETCH0 = 4'd0,
    ST_FETCH1 = 4'd1,
    ST_FETCH2 = 4'd2,
    ST_FETCH3 = 4'd3,
    ST_IDLE   = 4'd4,
    ST_DECODE = 4'd5,
    ST_OPER   = 4'd6,
    ST_EXEC   = 4'd7,
    ST_WB     = 4'd8,
    ST_PCUPD  = 4'd9,
    ST_HALTED = 4'd10
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
  } strobe_t;

endpackage
`default_nettype wire

// File: rtl/risc_ctl_decode.sv
`default_nettype none
// ============================================================================
// Module      : risc_ctl_decode
// Description : Combinational opcode classifier. Any code above 7 (only
//               possible when OPW > 3) is classed as NOP.
// Ports       : i_opcode     - IR opcode field (OPW bits)
//               o_is_alu_ld  - ADD / ANDD / XORR / LDA
//               o_is_sto     - STO
//               o_is_jmp     - JMP
//               o_is_skz     - SKZ
//               o_is_hlt     - HLT
//               o_is_nop     - code above 7
// Revision    : 1.0 - initial release
// ============================================================================
module risc_ctl_decode
  import risc_ctl_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] i_opcode,
  output logic           o_is_alu_ld,
  output logic           o_is_sto,
  output logic           o_is_jmp,
  output logic           o_is_skz,
  output logic           o_is_hlt,
  output logic           o_is_nop
);

  logic       w_hi;
  logic [2:0] w_lo;

  assign w_lo = i_opcode[2:0];

  generate
    if (OPW > 3) begin : g_wide
      assign w_hi = |i_opcode[OPW-1:3];
    end else begin : g_narrow
      assign w_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    o_is_alu_ld = 1'b0;
    o_is_sto    = 1'b0;
    o_is_jmp    = 1'b0;
    o_is_skz    = 1'b0;
    o_is_hlt    = 1'b0;
    o_is_nop    = w_hi;
    if (!w_hi) begin
      case (w_lo)
        HLT:                   o_is_hlt    = 1'b1;
        SKZ:                   o_is_skz    = 1'b1;
        ADD, ANDD, XORR, LDA:  o_is_alu_ld = 1'b1;
        STO:                   o_is_sto    = 1'b1;
        JMP:                   o_is_jmp    = 1'b1;
        default:               o_is_nop    = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/risc_ctl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : risc_ctl_fsm
// Description : RISC CPU control sequencer. Steps FETCH0..FETCH(n-1), IDLE,
//               DECODE, OPER, EXEC, WB, PCUPD per instruction (HLT diverts
//               to a sticky HALTED state). All flops update on the falling
//               edge of clk1; every output is registered.
// Ports       : clk1, rst (sync, active-high), ena (0 = pause), opcode,
//               zero, mem_ready (rd/wr access complete), cont (resume from
//               HALTED); strobes inc_pc, load_acc, load_pc, rd, wr, load_ir,
//               datactl_ena; halt, instr_done, phase (state code).
// Options     : RISC_CTL_STALL_CNT_EN adds stall_cnt[15:0], a saturating
//               count of wait-state cycles, cleared on each instr_done.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_ctl_fsm
  import risc_ctl_pkg::*;
#(
  parameter int OPW       = 3,
  parameter int FETCH_CYC = 2
) (
  input  logic           clk1,
  input  logic           rst,
  input  logic           ena,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  input  logic           cont,
  output logic           inc_pc,
  output logic           load_acc,
  output logic           load_pc,
  output logic           rd,
  output logic           wr,
  output logic           load_ir,
  output logic           datactl_ena,
  output logic           halt,
  output logic           instr_done,
  output logic [3:0]     phase
`ifdef RISC_CTL_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam logic [1:0] LAST_FETCH = 2'(FETCH_CYC - 1);

  state_t  r_state, w_nxt_state;
  strobe_t r_str, w_nxt_str, w_ent_str;
  logic    r_halt, w_nxt_halt;
  logic    r_done, w_nxt_done;
  logic    r_zl, w_nxt_zl;
  logic    r_paused, w_nxt_paused;
  logic    w_illegal, w_stall;
  logic    w_is_alu_ld, w_is_sto, w_is_jmp, w_is_skz, w_is_hlt, w_is_nop;

  risc_ctl_decode #(.OPW(OPW)) u_decode (
    .i_opcode    (opcode),
    .o_is_alu_ld (w_is_alu_ld),
    .o_is_sto    (w_is_sto),
    .o_is_jmp    (w_is_jmp),
    .o_is_skz    (w_is_skz),
    .o_is_hlt    (w_is_hlt),
    .o_is_nop    (w_is_nop)
  );

  // Next state. Priority: illegal code > pause > re-issue after pause >
  // wait-state hold > normal advance.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_zl     = r_zl;
    w_nxt_paused = 1'b0;
    w_nxt_done   = 1'b0;
    w_stall      = 1'b0;
    w_illegal    = (r_state > ST_HALTED);
    if (w_illegal) begin
      w_nxt_state = ST_FETCH0;
    end else if (!ena) begin
      w_nxt_paused = 1'b1;
    end else if (r_paused) begin
      // Hold the state for one edge so its outputs are presented again.
      w_nxt_state = r_state;
    end else if ((r_str.rd || r_str.wr) && !mem_ready) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_FETCH3: begin
          if (r_state[1:0] >= LAST_FETCH) w_nxt_state = ST_IDLE;
          else w_nxt_state = state_t'({2'b00, r_state[1:0] + 2'd1});
        end
        ST_IDLE:   w_nxt_state = ST_DECODE;
        ST_DECODE: begin
          if (w_is_hlt) begin
            w_nxt_state = ST_HALTED;
          end else begin
            w_nxt_state = ST_OPER;
            w_nxt_zl    = zero;   // zero is frozen for the rest of the instruction
          end
        end
        ST_OPER:   w_nxt_state = ST_EXEC;
        ST_EXEC:   w_nxt_state = ST_WB;
        ST_WB:     w_nxt_state = ST_PCUPD;
        ST_PCUPD: begin
          w_nxt_state = ST_FETCH0;
          w_nxt_done  = 1'b1;
        end
        ST_HALTED: if (cont) w_nxt_state = ST_FETCH0;
        default:   w_nxt_state = ST_FETCH0;
      endcase
    end
  end

  // Strobes presented on entry to (or re-issue of) a state.
  always_comb begin
    w_ent_str = '0;
    case (w_nxt_state)
      ST_FETCH0: begin
        w_ent_str.rd      = 1'b1;
        w_ent_str.load_ir = 1'b1;
      end
      ST_FETCH1, ST_FETCH2, ST_FETCH3: begin
        w_ent_str.rd      = 1'b1;
        w_ent_str.load_ir = 1'b1;
        w_ent_str.inc_pc  = 1'b1;
      end
      ST_DECODE: w_ent_str.inc_pc = !w_is_hlt;
      ST_OPER: begin
        if (w_is_nop || w_is_skz) w_ent_str = '0;
        else if (w_is_jmp)        w_ent_str.load_pc = 1'b1;
        else if (w_is_alu_ld)     w_ent_str.rd = 1'b1;
        else if (w_is_sto)        w_ent_str.datactl_ena = 1'b1;
      end
      ST_EXEC: begin
        w_ent_str.rd          = w_is_alu_ld;
        w_ent_str.inc_pc      = w_is_jmp || (w_is_skz && w_nxt_zl);
        w_ent_str.load_pc     = w_is_jmp;
        w_ent_str.wr          = w_is_sto;
        w_ent_str.datactl_ena = w_is_sto;
      end
      ST_WB: begin
        w_ent_str.rd          = w_is_alu_ld;
        w_ent_str.load_acc    = w_is_alu_ld;
        w_ent_str.datactl_ena = w_is_sto;
      end
      ST_PCUPD:  w_ent_str.inc_pc = w_is_skz && w_nxt_zl;
      default:   w_ent_str = '0;
    endcase
  end

  always_comb begin
    w_nxt_str  = w_ent_str;
    w_nxt_halt = (w_nxt_state == ST_HALTED);
    if (w_illegal) begin
      w_nxt_str  = '0;
      w_nxt_halt = 1'b0;
    end else if (!ena) begin
      w_nxt_str  = '0;
      w_nxt_halt = r_halt;
    end else if (w_stall) begin
      // PC-affecting strobes fire only in the first cycle of a state.
      w_nxt_str         = r_str;
      w_nxt_str.inc_pc  = 1'b0;
      w_nxt_str.load_pc = 1'b0;
      w_nxt_halt        = r_halt;
    end
  end

  always_ff @(negedge clk1) begin
    if (rst) begin
      r_state  <= ST_FETCH0;
      r_str    <= '0;
      r_halt   <= 1'b0;
      r_done   <= 1'b0;
      r_zl     <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_str    <= w_nxt_str;
      r_halt   <= w_nxt_halt;
      r_done   <= w_nxt_done;
      r_zl     <= w_nxt_zl;
      r_paused <= w_nxt_paused;
    end
  end

`ifdef RISC_CTL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(negedge clk1) begin
    if (rst || w_nxt_done) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign inc_pc      = r_str.inc_pc;
  assign load_acc    = r_str.load_acc;
  assign load_pc     = r_str.load_pc;
  assign rd          = r_str.rd;
  assign wr          = r_str.wr;
  assign load_ir     = r_str.load_ir;
  assign datactl_ena = r_str.datactl_ena;
  assign halt        = r_halt;
  assign instr_done  = r_done;
  assign phase       = r_state;

endmodule
`default_nettype wire
